// File: rtl/accel_pkg.sv
// Shared constants and FSM state type for the matrix accelerator result path.
package accel_pkg;

    localparam int unsigned TILE           = 16;
    localparam int unsigned ACC_W          = 24;
    localparam int unsigned RES_W          = 32;
    localparam int unsigned ADDR_W         = 17;
    localparam int unsigned TILE_COLS      = 512 / TILE;
    localparam int unsigned WORDS_PER_TILE = TILE * TILE / 2;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ISSUE,
        W_DRAIN,
        W_FIN
    } wr_state_e;

endpackage

// File: rtl/result_packer.sv
// Sign-extends array results to RES_W and packs even/odd column pairs into one word.
module result_packer
    import accel_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_odd,
    input  logic [ACC_W-1:0]     in_data,
    output logic [2*RES_W-1:0]   pack_word,
    output logic                 word_valid
);

    logic [RES_W-1:0] sext;
    logic [RES_W-1:0] pack_hi_q;

    assign sext = {{(RES_W - ACC_W){in_data[ACC_W-1]}}, in_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            pack_hi_q  <= '0;
            pack_word  <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= in_valid && in_odd;
            if (in_valid && !in_odd) begin
                pack_hi_q <= sext;
            end
            if (in_valid && in_odd) begin
                pack_word <= {pack_hi_q, sext};
            end
        end
    end

endmodule

// File: rtl/result_writer.sv
// Drains one 16x16 accumulator tile into result memory as 128 packed 64-bit words.
module result_writer
    import accel_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [5:0]        tile_row,
    input  logic [4:0]        tile_col,
    output logic [4:0]        arr_addr1,
    output logic [3:0]        arr_addr2,
    input  logic [ACC_W-1:0]  arr_dout,
    output logic [ADDR_W-1:0] res_addr,
    output logic [63:0]       res_data,
    output logic              res_write_enb,
    output logic              busyb,
    output logic              done
);

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [4:0]        row_q, row_d;
    logic [3:0]        col_q, col_d;
    // Coordinates of the element whose data is on arr_dout this cycle.
    logic              cap_valid_q;
    logic [4:0]        cap_row_q;
    logic [3:0]        cap_col_q;
    logic [ADDR_W-1:0] res_addr_q;
    logic              done_q;
    logic              word_valid;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        row_d   = row_q;
        col_d   = col_q;
        unique case (state_q)
            W_IDLE: begin
                if (start) begin
                    base_d  = ADDR_W'((32'(tile_row) * TILE_COLS + 32'(tile_col))
                                      * WORDS_PER_TILE);
                    row_d   = '0;
                    col_d   = '0;
                    state_d = W_ISSUE;
                end
            end
            W_ISSUE: begin
                if (col_q == 4'(TILE - 1)) begin
                    col_d = '0;
                    if (row_q == 5'(TILE - 1)) begin
                        row_d   = '0;
                        state_d = W_DRAIN;
                    end else begin
                        row_d = row_q + 5'd1;
                    end
                end else begin
                    col_d = col_q + 4'd1;
                end
            end
            W_DRAIN: state_d = W_FIN;
            W_FIN:   state_d = W_IDLE;
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= W_IDLE;
            base_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            cap_valid_q <= 1'b0;
            cap_row_q   <= '0;
            cap_col_q   <= '0;
            res_addr_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cap_valid_q <= (state_q == W_ISSUE);
            cap_row_q   <= row_q;
            cap_col_q   <= col_q;
            done_q      <= (state_q == W_FIN);
            // Address is registered alongside the packed word so both appear with the strobe.
            if (cap_valid_q && cap_col_q[0]) begin
                res_addr_q <= base_q + ADDR_W'(32'(cap_row_q) * (TILE / 2) + 32'(cap_col_q) / 2);
            end
        end
    end

    result_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (cap_valid_q),
        .in_odd     (cap_col_q[0]),
        .in_data    (arr_dout),
        .pack_word  (res_data),
        .word_valid (word_valid)
    );

    assign arr_addr1     = row_q;
    assign arr_addr2     = col_q;
    assign res_addr      = res_addr_q;
    assign res_write_enb = ~word_valid;
    assign busyb         = (state_q != W_IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_result_writer.sv
// Randomized self-checking bench for result_writer against a tile-level word/timing model.
module tb_result_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  tile_row;
    logic [4:0]  tile_col;
    logic [4:0]  arr_addr1;
    logic [3:0]  arr_addr2;
    logic [23:0] arr_dout;
    logic [16:0] res_addr;
    logic [63:0] res_data;
    logic        res_write_enb;
    logic        busyb;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int mode    = 0;
    int start_cyc;
    logic [23:0] tbl [256];

    logic [16:0] sq_addr [$];
    logic [63:0] sq_data [$];
    int          sq_cyc  [$];
    int          dq      [$];
    logic        hold_en;
    logic        have_last;
    logic [16:0] last_addr;
    logic [63:0] last_data;

    result_writer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .tile_row      (tile_row),
        .tile_col      (tile_col),
        .arr_addr1     (arr_addr1),
        .arr_addr2     (arr_addr2),
        .arr_dout      (arr_dout),
        .res_addr      (res_addr),
        .res_data      (res_data),
        .res_write_enb (res_write_enb),
        .busyb         (busyb),
        .done          (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] elem(input int m, input int r, input int c);
        case (m)
            0:       return 24'(r * 16 + c);
            1:       return 24'h800000;
            2:       return 24'h7FFFFF;
            default: return tbl[(r * 16 + c) % 256];
        endcase
    endfunction

    // Synchronous-read array: data one cycle after the address.
    always @(posedge clk) arr_dout <= elem(mode, int'(arr_addr1), int'(arr_addr2));

    function automatic int exp_base(input int row, input int col);
        return ((row * 32 + col) * 128) % 131072;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (res_write_enb === 1'b0) begin
            sq_addr.push_back(res_addr);
            sq_data.push_back(res_data);
            sq_cyc.push_back(cyc);
            last_addr = res_addr;
            last_data = res_data;
            have_last = 1'b1;
        end else if (hold_en && have_last) begin
            check("hold_addr", 64'(res_addr), 64'(last_addr));
            check("hold_data", res_data, last_data);
        end
        if (done === 1'b1) dq.push_back(cyc);
    end

    task automatic clear_q();
        sq_addr.delete();
        sq_data.delete();
        sq_cyc.delete();
        dq.delete();
    endtask

    task automatic pulse_start(input int row, input int col);
        @(negedge clk);
        tile_row  = 6'(row);
        tile_col  = 5'(col);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start    = 1'b0;
        tile_row = 6'($urandom);
        tile_col = 5'($urandom);
        check("busy_after_start", 64'(busyb), 64'd1);
    endtask

    task automatic begin_run(input int row, input int col);
        clear_q();
        pulse_start(row, col);
    endtask

    task automatic wait_done(input string tag, input int n_before);
        for (int i = 0; i < 400 && dq.size() <= n_before; i++) begin
            @(negedge clk);
            #1;
        end
        check({tag, "_done_seen"}, 64'(dq.size() > n_before), 64'd1);
    endtask

    task automatic check_run(input string tag, input int first, input int base, input int s_cyc);
        for (int k = 0; k < 128; k++) begin
            int          idx;
            int          r;
            int          c;
            logic [31:0] hi;
            logic [31:0] lo;
            idx = first + k;
            if (idx >= sq_addr.size()) break;
            r  = k / 8;
            c  = (2 * k) % 16;
            hi = 32'(int'($signed(elem(mode, r, c))));
            lo = 32'(int'($signed(elem(mode, r, c + 1))));
            check({tag, "_addr"}, 64'(sq_addr[idx]), 64'((base + k) % 131072));
            check({tag, "_data"}, sq_data[idx], {hi, lo});
            check({tag, "_when"}, 64'(sq_cyc[idx]), 64'(s_cyc + 4 + 2 * k));
        end
    endtask

    task automatic finish_run(input string tag, input int row, input int col);
        wait_done(tag, 0);
        repeat (6) @(negedge clk);
        #1;
        check({tag, "_nwords"}, 64'(sq_addr.size()), 64'd128);
        check_run(tag, 0, exp_base(row, col), start_cyc);
        check({tag, "_ndone"}, 64'(dq.size()), 64'd1);
        if (dq.size() > 0) check({tag, "_done_cyc"}, 64'(dq[0]), 64'(start_cyc + 259));
    endtask

    initial begin
        int r1, c1, r2, c2, s1, s2, n;
        rst       = 1'b1;
        start     = 1'b0;
        tile_row  = '0;
        tile_col  = '0;
        hold_en   = 1'b1;
        have_last = 1'b0;
        foreach (tbl[i]) tbl[i] = 24'($urandom);
        repeat (3) @(negedge clk);
        check("rst_addr1", 64'(arr_addr1), 64'd0);
        check("rst_addr2", 64'(arr_addr2), 64'd0);
        check("rst_res_addr", 64'(res_addr), 64'd0);
        check("rst_res_data", res_data, 64'd0);
        check("rst_wenb", 64'(res_write_enb), 64'd1);
        check("rst_busyb", 64'(busyb), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;

        // Index ramp on tile (0,0)
        mode = 0;
        begin_run(0, 0);
        finish_run("ramp", 0, 0);
        if (sq_data.size() >= 128) begin
            check("ramp_word0", sq_data[0], 64'h00000000_00000001);
            check("ramp_word127", sq_data[127], 64'h000000FE_000000FF);
        end

        // Sign-extension extremes
        mode = 1;
        begin_run(4, 9);
        finish_run("neg", 4, 9);
        if (sq_data.size() > 0) check("neg_word0", sq_data[0], 64'hFF800000_FF800000);
        mode = 2;
        begin_run(7, 3);
        finish_run("pos", 7, 3);
        if (sq_data.size() > 0) check("pos_word0", sq_data[0], 64'h007FFFFF_007FFFFF);

        // Address corners
        mode = 0;
        begin_run(31, 31);
        finish_run("last_tile", 31, 31);
        if (sq_addr.size() >= 128) begin
            check("last_first", 64'(sq_addr[0]), 64'd130944);
            check("last_last", 64'(sq_addr[127]), 64'd131071);
        end
        begin_run(1, 0);
        finish_run("tile10", 1, 0);
        if (sq_addr.size() > 0) check("tile10_first", 64'(sq_addr[0]), 64'd4096);

        // Start while busy is ignored
        begin_run(2, 7);
        repeat (99) @(negedge clk);
        tile_row = 6'd5;
        tile_col = 5'd5;
        start    = 1'b1;
        check("busy_at_restart", 64'(busyb), 64'd1);
        @(negedge clk);
        start = 1'b0;
        finish_run("ign_start", 2, 7);

        // Reset mid-drain
        hold_en = 1'b0;
        begin_run(3, 1);
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("abort_wenb", 64'(res_write_enb), 64'd1);
        check("abort_busyb", 64'(busyb), 64'd0);
        check("abort_data", res_data, 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("abort_nwords", 64'(sq_addr.size()), 64'd24);
        check("abort_idle", 64'(busyb), 64'd0);
        check("abort_nodone", 64'(dq.size()), 64'd0);
        have_last = 1'b0;
        hold_en   = 1'b1;
        begin_run(3, 4);
        finish_run("after_rst", 3, 4);

        // Back-to-back tiles, second start in the cycle after done
        mode = 3;
        r1 = $urandom_range(0, 63);
        c1 = $urandom_range(0, 31);
        r2 = $urandom_range(0, 63);
        c2 = $urandom_range(0, 31);
        begin_run(r1, c1);
        s1 = start_cyc;
        wait_done("b2b_a", 0);
        pulse_start(r2, c2);
        s2 = start_cyc;
        wait_done("b2b_b", 1);
        repeat (6) @(negedge clk);
        #1;
        check("b2b_nwords", 64'(sq_addr.size()), 64'd256);
        check("b2b_ndone", 64'(dq.size()), 64'd2);
        check_run("b2b_a", 0, exp_base(r1, c1), s1);
        check_run("b2b_b", 128, exp_base(r2, c2), s2);
        if (dq.size() >= 2) begin
            check("b2b_done_a", 64'(dq[0]), 64'(s1 + 259));
            check("b2b_done_b", 64'(dq[1]), 64'(s2 + 259));
        end

        // Random data, random tiles
        for (int t = 0; t < 3; t++) begin
            foreach (tbl[i]) tbl[i] = 24'($urandom);
            r1 = $urandom_range(0, 63);
            c1 = $urandom_range(0, 31);
            n  = $urandom_range(0, 5);
            repeat (n) @(negedge clk);
            begin_run(r1, c1);
            finish_run("rand", r1, c1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
